// File: rtl/data_mem_stall_unit.sv
// Multi-cycle data-memory stage: one outstanding word access with fixed latency, stalling the CPU until done.
// Optional per-op completion counters are enabled by defining DMEM_ACCESS_CNT_EN.
module data_mem_stall_unit #(
    parameter int DEPTH_WORDS = 128,
    parameter int LATENCY     = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] data_i,
    input  logic        MemRead_i,
    input  logic        MemWrite_i,
    output logic [31:0] data_o,
    output logic        stall_o,
    output logic        misalign_o
`ifdef DMEM_ACCESS_CNT_EN
    ,
    output logic [15:0] rd_cnt_o,
    output logic [15:0] wr_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t          state;
    logic [3:0]      cnt;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic            is_store_q;
    logic [31:0]     mem [DEPTH_WORDS];

    logic            req;
    logic            aligned_req;
    logic            finish;
    logic            unused_addr;

    assign req         = MemRead_i | MemWrite_i;
    assign misalign_o  = req & (addr_i[1:0] != 2'b00);
    assign aligned_req = req & (addr_i[1:0] == 2'b00);
    // Upper address bits are intentionally dropped so addresses wrap.
    assign unused_addr = ^addr_i[31:AW+2];

    // The completing BUSY cycle; a reset in that cycle aborts the access.
    assign finish = (state == BUSY) && (cnt == 4'd0) && !rst_i;

    always_comb begin
        stall_o = 1'b0;
        if (state == BUSY)
            stall_o = 1'b1;
        else if (state == IDLE)
            stall_o = aligned_req;
    end

    // Storage is not reset; contents survive rst_i.
    always_ff @(posedge clk_i) begin
        if (finish && is_store_q)
            mem[idx_q] <= wdata_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            idx_q      <= '0;
            wdata_q    <= 32'd0;
            is_store_q <= 1'b0;
            data_o     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (aligned_req) begin
                        idx_q      <= addr_i[AW+1:2];
                        wdata_q    <= data_i;
                        is_store_q <= MemWrite_i;
                        cnt        <= 4'(LATENCY - 1);
                        state      <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt != 4'd0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        if (!is_store_q)
                            data_o <= mem[idx_q];
                        state <= DONE;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef DMEM_ACCESS_CNT_EN
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_o <= 16'd0;
            wr_cnt_o <= 16'd0;
        end else if (finish) begin
            if (is_store_q && wr_cnt_o != 16'hFFFF)
                wr_cnt_o <= wr_cnt_o + 16'd1;
            if (!is_store_q && rd_cnt_o != 16'hFFFF)
                rd_cnt_o <= rd_cnt_o + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_data_mem_stall_unit.sv
// Self-checking bench for data_mem_stall_unit: directed scenarios plus random accesses against a word-array model.
// Define DMEM_ACCESS_CNT_EN to also check the access counters.
module tb_data_mem_stall_unit;

    localparam int DEPTH   = 128;
    localparam int LATENCY = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
`ifdef DMEM_ACCESS_CNT_EN
    logic [15:0] rd_cnt;
    logic [15:0] wr_cnt;
`endif

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_data;
    logic [31:0] exp_q[$];
    int          rd_n;
    int          wr_n;

    data_mem_stall_unit #(.DEPTH_WORDS(DEPTH), .LATENCY(LATENCY)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .addr_i     (addr),
        .data_i     (wdata),
        .MemRead_i  (mem_rd),
        .MemWrite_i (mem_wr),
        .data_o     (rdata),
        .stall_o    (stall),
        .misalign_o (misalign)
`ifdef DMEM_ACCESS_CNT_EN
        ,
        .rd_cnt_o   (rd_cnt),
        .wr_cnt_o   (wr_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_counts();
`ifdef DMEM_ACCESS_CNT_EN
        check("rd_cnt", {16'd0, rd_cnt}, 32'(rd_n > 65535 ? 65535 : rd_n));
        check("wr_cnt", {16'd0, wr_cnt}, 32'(wr_n > 65535 ? 65535 : wr_n));
`endif
    endtask

    // Inputs must be ignored while busy and in the completion cycle.
    task automatic drive_junk();
        mem_rd = 1'($urandom);
        mem_wr = 1'($urandom);
        addr   = $urandom;
        wdata  = $urandom;
    endtask

    // One access starting at the next negedge; checks the full stall profile and result.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
        int unsigned widx;
        @(negedge clk);
        mem_rd = rd;
        mem_wr = wr;
        addr   = a;
        wdata  = d;
        #1;
        if (a[1:0] != 2'b00) begin
            check("misalign", {31'd0, misalign}, 32'd1);
            check("stall_mis", {31'd0, stall}, 32'd0);
            @(negedge clk);
            #1;
            check("stall_mis_next", {31'd0, stall}, 32'd0);
            check("data_hold_mis", rdata, exp_data);
            return;
        end
        check("misalign_ok", {31'd0, misalign}, 32'd0);
        check("stall_accept", {31'd0, stall}, 32'd1);
        widx = (a / 4) % DEPTH;
        if (!wr)
            exp_q.push_back(model_mem[widx]);
        for (int k = 0; k < LATENCY; k++) begin
            @(negedge clk);
            drive_junk();
            #1;
            check("stall_busy", {31'd0, stall}, 32'd1);
        end
        @(negedge clk);
        drive_junk();
        #1;
        check("stall_done", {31'd0, stall}, 32'd0);
        if (wr) begin
            model_mem[widx] = d;
            wr_n++;
        end else begin
            exp_data = exp_q.pop_front();
            rd_n++;
        end
        check("data_o", rdata, exp_data);
        check_counts();
    endtask

    task automatic go_quiet();
        @(negedge clk);
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        #1;
        check("stall_quiet", {31'd0, stall}, 32'd0);
        check("data_quiet", rdata, exp_data);
    endtask

    initial begin
        rst    = 1'b1;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        exp_data = 32'd0;
        rd_n   = 0;
        wr_n   = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_stall", {31'd0, stall}, 32'd0);
        check("rst_data", rdata, 32'd0);
        check("rst_misalign", {31'd0, misalign}, 32'd0);
        check_counts();
        addr   = 32'h13;
        mem_rd = 1'b1;
        #1;
        check("rst_misalign_follow", {31'd0, misalign}, 32'd1);
        mem_rd = 1'b0;
        addr   = 32'd0;
        @(negedge clk);
        rst = 1'b0;

        // Directed scenarios
        access(1'b0, 1'b1, 32'h10, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        go_quiet();
        access(1'b1, 1'b1, 32'h20, 32'h12345678);
        access(1'b1, 1'b0, 32'h20, 32'h0);
        access(1'b0, 1'b1, 32'h13, 32'hFFFFFFFF);
        access(1'b1, 1'b0, 32'h10, 32'h0);
        check("load_after_misalign", rdata, 32'hDEADBEEF);
        access(1'b0, 1'b1, 32'h200, 32'hA5A5A5A5);
        access(1'b1, 1'b0, 32'h000, 32'h0);
        check("wrap_load", rdata, 32'hA5A5A5A5);

        // Reset during the second stall cycle aborts the store
        @(negedge clk);
        mem_rd = 1'b0;
        mem_wr = 1'b1;
        addr   = 32'h10;
        wdata  = 32'h11111111;
        #1;
        check("rb_accept", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rb_busy", {31'd0, stall}, 32'd1);
        @(negedge clk);
        rst    = 1'b0;
        mem_wr = 1'b0;
        addr   = 32'd0;
        wdata  = 32'd0;
        #1;
        exp_data = 32'd0;
        rd_n = 0;
        wr_n = 0;
        check("rb_stall", {31'd0, stall}, 32'd0);
        check("rb_data", rdata, 32'd0);
        check_counts();
        access(1'b1, 1'b0, 32'h10, 32'h0);
        check("rb_mem_untouched", rdata, 32'hDEADBEEF);

        // Fill the whole array through aliased addresses so every load is predictable
        for (int i = 0; i < DEPTH; i++)
            access(1'b0, 1'b1, (32'(i) * 4) | ($urandom & 32'hFFFF_FE00), $urandom);

        // Random mix of loads, stores, both strobes and misaligned requests
        for (int i = 0; i < 200; i++) begin
            logic rd;
            logic wr;
            logic [31:0] a;
            rd = 1'($urandom);
            wr = 1'($urandom);
            if (!rd && !wr)
                rd = 1'b1;
            a = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) == 0)
                a[1:0] = 2'($urandom_range(1, 3));
            access(rd, wr, a, $urandom);
        end
        go_quiet();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/data_mem_stall_unit.md
Name: data_mem_stall_unit

Overview:
- Multi-cycle data-memory stage downstream of the single-cycle CPU datapath.
- Consumes the ALU result as a byte address, the RT register value as write data, and the decoder's MemRead/MemWrite strobes.
- Returns load data and a stall that freezes the PC and register-file write until the access completes.
- Word-addressed storage with fixed access latency, one outstanding access.

Parameters:
DEPTH_WORDS, 128, number of 32-bit words; power of two, >=4.
LATENCY, 2, BUSY cycles per access; legal range 1..15.

Ports:
clk_i  input  1  clock, all state on rising edge
rst_i  input  1  synchronous, active-high reset
addr_i  input  32  byte address (ALU result)
data_i  input  32  store data (RT register value)
MemRead_i  input  1  load request
MemWrite_i  input  1  store request
data_o  output  32  load data, registered
stall_o  output  1  high while the access is incomplete; CPU holds PC and inhibits RegWrite
misalign_o  output  1  combinational; request present with addr_i[1:0]!=0

Behaviour:
- Reset: state IDLE, data_o=0, stall_o=0, misalign_o follows inputs, counter=0. Memory array contents are not cleared (see optional feature). Any pending store is discarded.
- req = MemRead_i | MemWrite_i. The op is a store if MemWrite_i=1; both high means the store wins.
- Word index = addr[log2(DEPTH_WORDS)+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Misaligned request (addr_i[1:0]!=0 with req=1):
  - misalign_o=1, stall_o=0.
  - No state change, no memory change, data_o holds.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - On aligned req: stall_o=1 combinationally in the same cycle.
  - Latch addr, data and op; cnt<=LATENCY-1; go to BUSY.
  - Otherwise stall_o=0.
- BUSY:
  - stall_o=1; inputs are ignored.
  - If cnt!=0, decrement cnt.
  - If cnt==0:
    - Store: mem[idx]<=latched data.
    - Load: data_o<=mem[idx].
    - Go to DONE.
- DONE:
  - stall_o=0 for exactly one cycle, and data_o is valid this cycle; the CPU advances at the next edge.
  - Always returns to IDLE; a new request is not accepted in DONE.
- Total stall per access is LATENCY+1 cycles, followed by 1 DONE cycle.
- Back-to-back accesses: next acceptance occurs in the IDLE cycle after DONE.
- data_o is unchanged by stores and retains the last load value until the next load or reset.
- Request dropped during BUSY: the access still completes as latched.
- Reset during BUSY: the access is aborted, memory is untouched, and the next cycle is IDLE.

Optional Feature:
- DMEM_ACCESS_CNT_EN defined:
  - Adds outputs rd_cnt_o[15:0] and wr_cnt_o[15:0].
  - Each increments on the BUSY->DONE edge of a completed load or store; saturating at 0xFFFF.
  - Misaligned and aborted accesses are not counted.
  - Both counters clear on rst_i.
- Undefined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Store, LATENCY=2:
  - Stimulus: MemWrite_i=1, addr 0x10, data 0xDEADBEEF.
  - Required: stall_o high 3 cycles, then DONE with stall_o=0; mem[4]=0xDEADBEEF; data_o stays 0.
- Load-back:
  - Stimulus: MemRead_i=1, addr 0x10.
  - Required: stall_o high 3 cycles; data_o=0xDEADBEEF in the DONE cycle and held afterwards.
- Simultaneous read+write:
  - Stimulus: both strobes, addr 0x20, data 0x12345678.
  - Required: treated as a store, mem[8]=0x12345678, data_o unchanged. A subsequent load of 0x20 returns 0x12345678.
- Misaligned:
  - Stimulus: MemWrite_i=1, addr 0x13, data 0xFFFFFFFF.
  - Required: misalign_o=1, stall_o=0. A load of 0x10 still returns 0xDEADBEEF.
- Wrap, DEPTH_WORDS=128:
  - Stimulus: store 0xA5A5A5A5 at 0x200.
  - Required: a load of 0x000 returns 0xA5A5A5A5.
- Reset in BUSY:
  - Stimulus: store 0x11111111 to 0x10; assert rst_i for 1 cycle during the second stall cycle.
  - Required: next cycle IDLE, stall_o=0, data_o=0. A later load of 0x10 returns 0xDEADBEEF.
  - With DMEM_ACCESS_CNT_EN: counters read 0 after reset.
